// File: rtl/dp_read_arbiter.sv
// Round-robin arbiter sharing one single-outstanding read port among NUM_REQ requesters.
// Define DP_ARB_TIMEOUT_EN to enable the WAIT-state watchdog (TIMEOUT_CYCLES).
module dp_read_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_err,
  output logic                       read_req,
  output logic [ADDR_W-1:0]          read_addr,
  input  logic [DATA_W-1:0]          read_data,
  input  logic                       read_data_valid,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       err_spurious
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] idx;
  logic            found;

`ifdef DP_ARB_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic        rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign rsp_err        = 1'b0;
`endif

  // Search starts just above the last owner so the previous winner goes to the back.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path can infer a latch.
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Accept pulse is combinational so it coincides with the edge that latches the grant.
  assign req_ready = (resetn && state == IDLE && found) ? (NUM_REQ'(1) << winner) : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      rr_ptr       <= ID_W'(NUM_REQ - 1);
      grant_id     <= '0;
      read_req     <= 1'b0;
      read_addr    <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      err_spurious <= 1'b0;
`ifdef DP_ARB_TIMEOUT_EN
      wait_cnt     <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge values.
      read_req  <= 1'b0;
      rsp_valid <= '0;
      if (read_data_valid && state != WAIT) err_spurious <= 1'b1;

      case (state)
        IDLE: begin
          if (found) begin
            grant_id  <= winner;
            read_addr <= req_addr[winner*ADDR_W +: ADDR_W];
            read_req  <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef DP_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (read_data_valid) begin
            rsp_data  <= read_data;
            rsp_valid <= NUM_REQ'(1) << grant_id;
`ifdef DP_ARB_TIMEOUT_EN
            rsp_err_q <= 1'b0;
`endif
            state     <= RESP;
          end
`ifdef DP_ARB_TIMEOUT_EN
          else if (wait_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            rsp_data  <= '0;
            rsp_valid <= NUM_REQ'(1) << grant_id;
            rsp_err_q <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
`endif
        end
        RESP: begin
          rr_ptr <= grant_id;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_read_arbiter.sv
// Scoreboard bench for dp_read_arbiter: stimulus queues expected grants/responses,
// a negedge monitor pops and compares them; a behavioural adapter answers reads.
`timescale 1ns/1ps
module tb_dp_read_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  logic                      clk = 1'b0;
  logic                      resetn;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic                      read_req;
  logic [ADDR_W-1:0]         read_addr;
  logic [DATA_W-1:0]         read_data;
  logic                      read_data_valid;
  logic                      busy;
  logic [0:0]                grant_id;
  logic                      err_spurious;

  dp_read_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .read_req(read_req), .read_addr(read_addr), .read_data(read_data),
    .read_data_valid(read_data_valid), .busy(busy), .grant_id(grant_id),
    .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  typedef struct { logic [0:0] id; logic [31:0] addr; } gnt_t;
  typedef struct { logic [1:0] onehot; logic [31:0] data; logic err; int lat; } rsp_t;

  gnt_t gnt_q[$];
  rsp_t rsp_q[$];
  int   grant_cycles[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   grant_cnt = 0;
  int   last_grant = 0;
  int   adapter_delay = 1;
  int   spur_issue = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // External memory contents seen through the adapter.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    case (a)
      32'h1000: return 32'hDEADBEEF;
      32'h2000: return 32'hCAFEF00D;
      32'h3000: return 32'h12345678;
      32'h4000: return 32'h0BADC0DE;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic expect_grant(input logic [0:0] id, input logic [31:0] addr);
    gnt_t g;
    g.id = id;
    g.addr = addr;
    gnt_q.push_back(g);
  endtask

  task automatic expect_txn(input logic [0:0] id, input logic [31:0] addr,
                            input logic [31:0] data, input logic err, input int lat);
    rsp_t r;
    expect_grant(id, addr);
    r.onehot = 2'b01 << id;
    r.data = data;
    r.err = err;
    r.lat = lat;
    rsp_q.push_back(r);
  endtask

  // Adapter: answers read_req after adapter_delay cycles (0 = never); can inject strobes.
  initial begin
    int pend = 0;
    int spur_done = 0;
    logic [31:0] pend_data = '0;
    read_data_valid = 1'b0;
    read_data = '0;
    forever begin
      @(posedge clk); #1;
      read_data_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          read_data_valid = 1'b1;
          read_data = pend_data;
        end
      end
      if (read_req && adapter_delay > 0) begin
        pend = adapter_delay;
        pend_data = mem_data(read_addr);
      end
      if (spur_issue != spur_done) begin
        spur_done++;
        read_data_valid = 1'b1;
        read_data = 32'h5A5A_5A5A;
      end
    end
  end

  // Monitor: compares grants, issued addresses and responses against the queues.
  initial begin
    gnt_t g;
    rsp_t r;
    gnt_t cur;
    cur.id = '0;
    cur.addr = '0;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (req_ready != 0) begin
          grant_cnt++;
          grant_cycles.push_back(cyc);
          last_grant = cyc;
          if (gnt_q.size() == 0) check("unexpected_grant", req_ready, 0);
          else begin
            g = gnt_q.pop_front();
            check("req_ready", req_ready, 2'b01 << g.id);
            check("busy_at_grant", busy, 0);
            cur = g;
          end
        end
        if (read_req) begin
          check("read_addr", read_addr, cur.addr);
          check("grant_id", grant_id, cur.id);
        end
        if (rsp_valid != 0) begin
          if (rsp_q.size() == 0) check("unexpected_rsp", rsp_valid, 0);
          else begin
            r = rsp_q.pop_front();
            check("rsp_valid", rsp_valid, r.onehot);
            check("rsp_data", rsp_data, r.data);
            check("rsp_err", rsp_err, r.err);
            check("rsp_latency", cyc - last_grant, r.lat);
          end
        end
      end
    end
  end

  task automatic wait_grants(input int n, input int budget);
    int target;
    target = grant_cnt + n;
    for (int k = 0; k < budget && grant_cnt < target; k++) begin
      @(posedge clk); #1;
    end
    check("grants_reached", grant_cnt >= target, 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget && (busy || rsp_q.size() != 0); k++) begin
      @(posedge clk); #1;
    end
    check("idle_reached", busy || rsp_q.size() != 0, 0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {req_ready, rsp_valid, rsp_err, read_req, busy, grant_id, err_spurious, read_addr}, 0);
    check({name, "_data"}, rsp_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gstart;
    int g0;
    int busy_low;
    req_valid = '0;
    req_addr = '0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    resetn = 1'b1;
    @(posedge clk); #1;

    // Contention from reset: 0,1,0,1 with a 2-cycle adapter.
    adapter_delay = 2;
    req_addr = {32'h2000, 32'h1000};
    expect_txn(0, 32'h1000, 32'hDEADBEEF, 1'b0, 4);
    expect_txn(1, 32'h2000, 32'hCAFEF00D, 1'b0, 4);
    expect_txn(0, 32'h1000, 32'hDEADBEEF, 1'b0, 4);
    expect_txn(1, 32'h2000, 32'hCAFEF00D, 1'b0, 4);
    req_valid = 2'b11;
    wait_grants(4, 40);
    req_valid = 2'b00;
    wait_idle(40);

    // Single request; address changes after accept must not matter.
    expect_txn(0, 32'h1000, 32'hDEADBEEF, 1'b0, 4);
    req_valid = 2'b01;
    wait_grants(1, 20);
    req_addr = {32'h2000, 32'h7777};
    req_valid = 2'b00;
    wait_idle(20);

    // Back-to-back with zero-wait adapter: grants every 4 cycles, busy low once each.
    adapter_delay = 1;
    req_addr = {32'h4000, 32'h3000};
    expect_txn(1, 32'h4000, 32'h0BADC0DE, 1'b0, 3);
    expect_txn(0, 32'h3000, 32'h12345678, 1'b0, 3);
    expect_txn(1, 32'h4000, 32'h0BADC0DE, 1'b0, 3);
    expect_txn(0, 32'h3000, 32'h12345678, 1'b0, 3);
    gstart = grant_cycles.size();
    g0 = grant_cnt;
    busy_low = 0;
    req_valid = 2'b11;
    if (!busy) busy_low++;
    for (int k = 0; k < 40 && grant_cnt < g0 + 4; k++) begin
      @(posedge clk); #1;
      if (!busy) busy_low++;
    end
    req_valid = 2'b00;
    check("b2b_grant_count", grant_cycles.size() - gstart, 4);
    check("b2b_busy_low", busy_low, 4);
    for (int i = 1; i < 4; i++)
      if (grant_cycles.size() >= gstart + 4)
        check("b2b_grant_gap", grant_cycles[gstart+i] - grant_cycles[gstart+i-1], 4);
    wait_idle(20);

    // Spurious strobe while idle.
    check("spur_before", err_spurious, 0);
    spur_issue++;
    repeat (3) begin @(posedge clk); #1; end
    check("spur_sticky", err_spurious, 1);
    check("spur_stays_idle", busy, 0);

    // Reset during WAIT; the adapter's late answer becomes spurious.
    adapter_delay = 3;
    req_addr = {32'h2000, 32'h1000};
    expect_grant(1, 32'h2000);
    req_valid = 2'b10;
    wait_grants(1, 20);
    req_valid = 2'b00;
    @(posedge clk); #1;
    check("in_wait_before_reset", busy, 1);
    resetn = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("late_strobe_spurious", err_spurious, 1);
    check("late_strobe_idle", busy, 0);

    // After reset requester 0 wins first when both request, then 1 alone.
    adapter_delay = 1;
    expect_txn(0, 32'h1000, 32'hDEADBEEF, 1'b0, 3);
    req_valid = 2'b11;
    wait_grants(1, 20);
    req_valid = 2'b00;
    wait_idle(20);
    expect_txn(1, 32'h2000, 32'hCAFEF00D, 1'b0, 3);
    req_valid = 2'b10;
    wait_grants(1, 20);
    req_valid = 2'b00;
    wait_idle(20);

`ifdef DP_ARB_TIMEOUT_EN
    // No response: watchdog answers 16 WAIT cycles later with an error.
    adapter_delay = 0;
    expect_txn(0, 32'h1000, 32'h0, 1'b1, 18);
    req_valid = 2'b01;
    wait_grants(1, 20);
    req_valid = 2'b00;
    wait_idle(60);
`endif

    check("grant_queue_empty", gnt_q.size(), 0);
    check("rsp_queue_empty", rsp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
